// File: rtl/axis_spm_dac_serializer.sv
// Four-channel AXI-stream sink that latches one X/Y/Z/U sample set per frame and shifts
// 20-bit DAC codes out over a shared SPI bus, then pulses LDAC. Define SPM_DAC_SATURATE_EN to clamp codes.
module axis_spm_dac_serializer #(
    parameter int CLK_DIV     = 2,
    parameter int GAIN_SHIFT  = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int LDAC_CYCLES = 2
) (
    input  logic        a_clk,
    input  logic        a_resetn,
    input  logic [31:0] S_AXIS1_tdata,
    input  logic        S_AXIS1_tvalid,
    output logic        S_AXIS1_tready,
    input  logic [31:0] S_AXIS2_tdata,
    input  logic        S_AXIS2_tvalid,
    output logic        S_AXIS2_tready,
    input  logic [31:0] S_AXIS3_tdata,
    input  logic        S_AXIS3_tvalid,
    output logic        S_AXIS3_tready,
    input  logic [31:0] S_AXIS4_tdata,
    input  logic        S_AXIS4_tvalid,
    output logic        S_AXIS4_tready,
    output logic        dac_sclk,
    output logic        dac_sync_n,
    output logic        dac_sdo,
    output logic        dac_ldac_n,
    output logic        frame_busy,
    output logic [31:0] frame_count
);

    localparam int MAX_A   = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int MAX_CNT = (MAX_A > LDAC_CYCLES) ? MAX_A : LDAC_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] LDAC_LAST = CW'(LDAC_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SHIFT, S_GAP, S_LDAC} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          r_hi;
    logic [4:0]    r_bit;
    logic [1:0]    r_ch;
    logic [31:0]   r_frame_cnt;
    logic [19:0]   r_code [4];

    logic          w_all_valid;
    logic          w_div_end;
    logic          w_shift_done;
    logic          w_gap_done;
    logic          w_ldac_done;
    logic          w_ready;
    logic [23:0]   w_word;

    function automatic logic [19:0] to_code(input logic [31:0] tdata);
`ifdef SPM_DAC_SATURATE_EN
        logic signed [31:0] v;
        v = $signed(tdata) >>> GAIN_SHIFT;
        if (v > 32'sd524287)
            return 20'h7FFFF;
        else if (v < -32'sd524288)
            return 20'h80000;
        else
            return v[19:0];
`else
        return 20'($signed(tdata) >>> GAIN_SHIFT);
`endif
    endfunction

    assign w_all_valid  = S_AXIS1_tvalid & S_AXIS2_tvalid & S_AXIS3_tvalid & S_AXIS4_tvalid;
    assign w_div_end    = (r_cnt == DIV_LAST);
    assign w_shift_done = w_div_end && r_hi && (r_bit == 5'd23);
    assign w_gap_done   = (r_cnt == GAP_LAST);
    assign w_ldac_done  = (r_cnt == LDAC_LAST);
    // Channel tag is 1-based so the DAC address field reads 1..4.
    assign w_word       = {{2'b00, r_ch} + 4'd1, r_code[r_ch]};

    // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_all_valid) w_next = S_LATCH;
            S_LATCH: w_next = S_SHIFT;
            S_SHIFT: if (w_shift_done) w_next = S_GAP;
            S_GAP:   if (w_gap_done) w_next = (r_ch == 2'd3) ? S_LDAC : S_SHIFT;
            S_LDAC:  if (w_ldac_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        w_ready    = 1'b0;
        dac_sclk   = 1'b0;
        dac_sync_n = 1'b1;
        dac_sdo    = 1'b0;
        dac_ldac_n = 1'b1;
        frame_busy = (r_state != S_IDLE);
        case (r_state)
            S_LATCH: w_ready = 1'b1;
            S_SHIFT: begin
                dac_sync_n = 1'b0;
                dac_sclk   = r_hi;
                dac_sdo    = w_word[5'd23 - r_bit];
            end
            S_LDAC:  dac_ldac_n = 1'b0;
            default: ;
        endcase
    end

    assign S_AXIS1_tready = w_ready;
    assign S_AXIS2_tready = w_ready;
    assign S_AXIS3_tready = w_ready;
    assign S_AXIS4_tready = w_ready;
    assign frame_count    = r_frame_cnt;

    // Counters restart on every state change; in SHIFT r_cnt times one SCLK half-period.
    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            r_cnt       <= '0;
            r_hi        <= 1'b0;
            r_bit       <= '0;
            r_ch        <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (r_state != w_next) begin
                r_cnt <= '0;
                r_hi  <= 1'b0;
                r_bit <= '0;
            end else if (r_state == S_SHIFT) begin
                if (w_div_end) begin
                    r_cnt <= '0;
                    r_hi  <= ~r_hi;
                    if (r_hi) r_bit <= r_bit + 5'd1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else if (r_state == S_GAP || r_state == S_LDAC) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (r_state == S_LATCH)
                r_ch <= '0;
            else if (r_state == S_GAP && w_gap_done && r_ch != 2'd3)
                r_ch <= r_ch + 2'd1;

            if (r_state == S_LDAC && w_ldac_done)
                r_frame_cnt <= r_frame_cnt + 32'd1;
        end
    end

    // NOTE: sample registers carry no reset; LATCH always writes them before SHIFT reads them.
    always_ff @(posedge a_clk) begin
        if (r_state == S_LATCH) begin
            r_code[0] <= to_code(S_AXIS1_tdata);
            r_code[1] <= to_code(S_AXIS2_tdata);
            r_code[2] <= to_code(S_AXIS3_tdata);
            r_code[3] <= to_code(S_AXIS4_tdata);
        end
    end

endmodule

// File: tb/tb_axis_spm_dac_serializer.sv
// Self-checking bench for axis_spm_dac_serializer: bus monitor plus an arithmetic reference model
// of the sample-to-word conversion; a second instance runs the minimum-timing configuration.
module tb_axis_spm_dac_serializer;

    localparam int GAIN_SHIFT = 8;

    logic        a_clk = 1'b0;
    logic        a_resetn = 1'b0;
    logic [31:0] d1, d2, d3, d4;
    logic        v1, v2, v3, v4;
    logic        r1, r2, r3, r4;
    logic        sclk, sync_n, sdo, ldac_n, busy;
    logic [31:0] fcount;
    logic [3:0]  w_rdy;

    logic        f_valid;
    logic [31:0] f_data;
    logic        fr1, fr2, fr3, fr4;
    logic        f_sclk, f_sync_n, f_sdo, f_ldac_n, f_busy;
    logic [31:0] f_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    axis_spm_dac_serializer u_dut (
        .a_clk(a_clk), .a_resetn(a_resetn),
        .S_AXIS1_tdata(d1), .S_AXIS1_tvalid(v1), .S_AXIS1_tready(r1),
        .S_AXIS2_tdata(d2), .S_AXIS2_tvalid(v2), .S_AXIS2_tready(r2),
        .S_AXIS3_tdata(d3), .S_AXIS3_tvalid(v3), .S_AXIS3_tready(r3),
        .S_AXIS4_tdata(d4), .S_AXIS4_tvalid(v4), .S_AXIS4_tready(r4),
        .dac_sclk(sclk), .dac_sync_n(sync_n), .dac_sdo(sdo), .dac_ldac_n(ldac_n),
        .frame_busy(busy), .frame_count(fcount)
    );

    axis_spm_dac_serializer #(.CLK_DIV(1), .GAP_CYCLES(1), .LDAC_CYCLES(1)) u_fast (
        .a_clk(a_clk), .a_resetn(a_resetn),
        .S_AXIS1_tdata(f_data), .S_AXIS1_tvalid(f_valid), .S_AXIS1_tready(fr1),
        .S_AXIS2_tdata(f_data), .S_AXIS2_tvalid(f_valid), .S_AXIS2_tready(fr2),
        .S_AXIS3_tdata(f_data), .S_AXIS3_tvalid(f_valid), .S_AXIS3_tready(fr3),
        .S_AXIS4_tdata(f_data), .S_AXIS4_tvalid(f_valid), .S_AXIS4_tready(fr4),
        .dac_sclk(f_sclk), .dac_sync_n(f_sync_n), .dac_sdo(f_sdo), .dac_ldac_n(f_ldac_n),
        .frame_busy(f_busy), .frame_count(f_count)
    );

    assign w_rdy = {r1, r2, r3, r4};

    always #5 a_clk = ~a_clk;
    always @(posedge a_clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Bus monitor for the default instance, sampled on the falling edge.
    logic [23:0] q_words[$];
    int          q_bits[$], q_len[$], q_ldac[$], q_rdy[$], q_latch[$];
    logic [23:0] m_word = '0;
    int          m_bits = 0, m_busy_run = 0, m_ldac_run = 0, m_rdy_run = 0;
    int          sdo_bad = 0, rdy_split = 0;
    logic        m_sclk_q = 1'b0, m_sync_q = 1'b1, m_sdo_q = 1'b0;

    always @(negedge a_clk) begin
        if (!sync_n && !m_sync_q && sdo !== m_sdo_q && !(m_sclk_q && !sclk)) sdo_bad++;
        if (!sync_n && sclk && !m_sclk_q) begin
            m_word = {m_word[22:0], sdo};
            m_bits++;
        end
        if (sync_n && !m_sync_q) begin
            q_words.push_back(m_word);
            q_bits.push_back(m_bits);
            m_word = '0;
            m_bits = 0;
        end
        if (!ldac_n) m_ldac_run++;
        else if (m_ldac_run != 0) begin q_ldac.push_back(m_ldac_run); m_ldac_run = 0; end
        if (busy) m_busy_run++;
        else if (m_busy_run != 0) begin q_len.push_back(m_busy_run); m_busy_run = 0; end
        if (w_rdy != 4'h0 && w_rdy != 4'hF) rdy_split++;
        if (w_rdy == 4'hF) begin
            if (m_rdy_run == 0) q_latch.push_back(cyc);
            m_rdy_run++;
        end else if (m_rdy_run != 0) begin
            q_rdy.push_back(m_rdy_run);
            m_rdy_run = 0;
        end
        m_sclk_q = sclk;
        m_sync_q = sync_n;
        m_sdo_q  = sdo;
    end

    // Minimal monitor for the fast instance: frame length and SCLK period.
    int f_len[$];
    int f_busy_run = 0, f_rise = 0, f_sclk_bad = 0, f_last_rise = -1;
    logic f_sclk_q = 1'b0;

    always @(negedge a_clk) begin
        if (f_busy) f_busy_run++;
        else if (f_busy_run != 0) begin f_len.push_back(f_busy_run); f_busy_run = 0; end
        if (f_sync_n) f_last_rise = -1;
        else if (f_sclk && !f_sclk_q) begin
            if (f_last_rise >= 0 && cyc - f_last_rise != 2) f_sclk_bad++;
            f_last_rise = cyc;
            f_rise++;
        end
        f_sclk_q = f_sclk;
    end

    logic [23:0] q_exp[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference conversion: floor division by 2^GAIN_SHIFT, optional clamp, keep 20 bits.
    function automatic logic [23:0] model_word(input int ch, input logic [31:0] d);
        longint x, dv, v;
        x  = longint'($signed(d));
        dv = longint'(1) << GAIN_SHIFT;
        v  = x / dv;
        if (x < 0 && (x % dv) != 0) v = v - 1;
`ifdef SPM_DAC_SATURATE_EN
        if (v > 524287)  v = 524287;
        if (v < -524288) v = -524288;
`endif
        v = v & 64'hFFFFF;
        return 24'(longint'(ch + 1) * 1048576 + v);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge a_clk);
    endtask

    task automatic drive(input logic [31:0] x, y, z, u, input logic [3:0] v);
        d1 = x; d2 = y; d3 = z; d4 = u;
        {v1, v2, v3, v4} = v;
    endtask

    task automatic push_model();
        q_exp.push_back(model_word(0, d1));
        q_exp.push_back(model_word(1, d2));
        q_exp.push_back(model_word(2, d3));
        q_exp.push_back(model_word(3, d4));
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (w_rdy != 4'hF && k < 1000) begin @(negedge a_clk); k++; end
        check(tag, w_rdy, 4'hF);
    endtask

    task automatic wait_count(input string tag, input int target);
        int k = 0;
        while (fcount != 32'(target) && k < 2000) begin @(negedge a_clk); k++; end
        check(tag, fcount, 64'(target));
    endtask

    // Handshake with the current data, then drop valid and scramble data.
    task automatic one_frame(input string tag);
        push_model();
        wait_ready({tag, "_ready"});
        tick(1);
        drive($urandom, $urandom, $urandom, $urandom, 4'h0);
    endtask

    task automatic compare_words(input string tag);
        check({tag, "_nwords"}, q_words.size(), q_exp.size());
        foreach (q_exp[i]) begin
            check($sformatf("%s_word%0d", tag, i), (i < q_words.size()) ? q_words[i] : 24'hx, q_exp[i]);
            check($sformatf("%s_bits%0d", tag, i), (i < q_bits.size()) ? q_bits[i] : -1, 24);
        end
        q_exp.delete();
        q_words.delete();
        q_bits.delete();
    endtask

    task automatic flush();
        q_words.delete(); q_bits.delete(); q_len.delete();
        q_ldac.delete(); q_rdy.delete(); q_latch.delete(); q_exp.delete();
    endtask

    initial begin
        drive('0, '0, '0, '0, 4'h0);
        f_valid = 1'b0;
        f_data  = 32'h0012_3400;
        tick(3);
        check("reset_outputs", {sclk, sync_n, sdo, ldac_n, w_rdy, busy}, 9'b0_1_0_1_0000_0);
        check("reset_count", fcount, 0);
        a_resetn = 1'b1;
        tick(2);

        // Directed frame with the reference sample set.
        drive(32'h0001_0000, 32'hFFFF_0000, 32'h0, 32'h0000_0100, 4'hF);
        wait_ready("t2_ready");
        tick(1);
        drive($urandom, $urandom, $urandom, $urandom, 4'h0);
        q_exp.push_back(24'h100100);
        q_exp.push_back(24'h2FFF00);
        q_exp.push_back(24'h300000);
        q_exp.push_back(24'h400001);
        wait_count("t2_count", 1);
        tick(2);
        check("t2_len", (q_len.size() == 1) ? q_len[0] : -1, 403);
        check("t2_ldac", (q_ldac.size() == 1) ? q_ldac[0] : -1, 2);
        check("t2_tready_pulse", (q_rdy.size() == 1) ? q_rdy[0] : -1, 1);
        check("t2_tready_split", rdy_split, 0);
        check("t2_sdo_stable", sdo_bad, 0);
        compare_words("t2");
        flush();

        // Extremes of the input range.
        drive(32'h7FFF_FFFF, 32'h8000_0000, $urandom, $urandom, 4'hF);
        wait_ready("t3_ready");
        tick(1);
`ifdef SPM_DAC_SATURATE_EN
        q_exp.push_back(24'h17FFFF);
        q_exp.push_back(24'h280000);
`else
        q_exp.push_back(24'h1FFFFF);
        q_exp.push_back(24'h200000);
`endif
        q_exp.push_back(model_word(2, d3));
        q_exp.push_back(model_word(3, d4));
        drive($urandom, $urandom, $urandom, $urandom, 4'h0);
        wait_count("t3_count", 2);
        tick(2);
        compare_words("t3");
        flush();

        // One stream not valid: nothing may start.
        drive($urandom, $urandom, $urandom, $urandom, 4'b1101);
        tick(10);
        check("t4_stall_idle", {sclk, sync_n, sdo, ldac_n, w_rdy, busy}, 9'b0_1_0_1_0000_0);
        check("t4_no_latch", q_latch.size(), 0);
        v3 = 1'b1;
        push_model();
        tick(1);
        check("t4_latch_next", w_rdy, 4'hF);
        tick(1);
        drive($urandom, $urandom, $urandom, $urandom, 4'h0);
        wait_count("t4_count", 3);
        tick(2);
        compare_words("t4");
        flush();

        // Reset during the second channel's shift.
        drive($urandom, $urandom, $urandom, $urandom, 4'hF);
        wait_ready("t5_ready");
        tick(1);
        drive($urandom, $urandom, $urandom, $urandom, 4'h0);
        begin
            int k = 0;
            while (!(q_words.size() == 1 && !sync_n) && k < 1000) begin @(negedge a_clk); k++; end
        end
        check("t5_reach_ch2", q_words.size(), 1);
        tick(20);
        a_resetn = 1'b0;
        #1;
        check("t5_reset_outputs", {sclk, sync_n, sdo, ldac_n, w_rdy, busy}, 9'b0_1_0_1_0000_0);
        check("t5_reset_count", fcount, 0);
        tick(3);
        check("t5_no_ldac", q_ldac.size(), 0);
        a_resetn = 1'b1;
        tick(2);
        flush();
        drive($urandom, $urandom, $urandom, $urandom, 4'hF);
        one_frame("t5b");
        wait_count("t5b_count", 1);
        tick(2);
        check("t5b_len", (q_len.size() == 1) ? q_len[0] : -1, 403);
        compare_words("t5b");

        // Three back-to-back frames with valid held high, fresh data after each handshake.
        a_resetn = 1'b0;
        tick(2);
        a_resetn = 1'b1;
        tick(1);
        flush();
        for (int f = 0; f < 3; f++) begin
            drive($urandom, $urandom, $urandom, $urandom, 4'hF);
            push_model();
            wait_ready($sformatf("t6_ready%0d", f));
            tick(1);
        end
        drive($urandom, $urandom, $urandom, $urandom, 4'h0);
        wait_count("t6_count", 3);
        tick(2);
        check("t6_nlatch", q_latch.size(), 3);
        if (q_latch.size() == 3) begin
            check("t6_spacing01", q_latch[1] - q_latch[0], 404);
            check("t6_spacing12", q_latch[2] - q_latch[1], 404);
        end
        compare_words("t6");
        check("t6_sdo_stable", sdo_bad, 0);

        // Minimum-timing configuration.
        f_valid = 1'b1;
        begin
            int k = 0;
            while (!(fr1 && fr2 && fr3 && fr4) && k < 100) begin @(negedge a_clk); k++; end
        end
        check("t7_ready", {fr1, fr2, fr3, fr4}, 4'hF);
        tick(1);
        f_valid = 1'b0;
        begin
            int k = 0;
            while (f_count != 32'd1 && k < 1000) begin @(negedge a_clk); k++; end
        end
        check("t7_count", f_count, 1);
        tick(2);
        check("t7_len", (f_len.size() == 1) ? f_len[0] : -1, 198);
        check("t7_rises", f_rise, 96);
        check("t7_sclk_period", f_sclk_bad, 0);
        check("t7_idle", {f_sclk, f_sync_n, f_sdo, f_ldac_n, f_busy}, 5'b0_1_0_1_0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_spm_dac_serializer.md
Name: axis_spm_dac_serializer

Overview:
- AXI-stream sink for the four SPM control streams: X, Y, Z and bias U.
- Each frame, it latches one sample per channel and scales/clamps each to a 20-bit two's-complement DAC code.
- Codes are shifted out MSB-first over a shared SPI-style bus to a 4-channel DAC, then a single LDAC pulse updates all outputs together.
- Sits between the SPM control vector generator and the external DAC pins.

Parameters:
- CLK_DIV, 2: a_clk cycles per SCLK half-period (≥1).
- GAIN_SHIFT, 8: arithmetic right shift applied to 32-bit signed tdata before clamping.
- GAP_CYCLES, 4: a_clk cycles with dac_sync_n high between channel words (≥1).
- LDAC_CYCLES, 2: a_clk cycles dac_ldac_n is held low per frame (≥1).

Ports:
- a_clk  in  1  system clock.
- a_resetn  in  1  async active-low reset.
- S_AXIS1_tdata  in  32  X sample, signed.
- S_AXIS1_tvalid  in  1.
- S_AXIS1_tready  out  1.
- S_AXIS2_tdata/tvalid/tready  in/in/out  32/1/1  Y stream.
- S_AXIS3_tdata/tvalid/tready  in/in/out  32/1/1  Z stream.
- S_AXIS4_tdata/tvalid/tready  in/in/out  32/1/1  bias U stream.
- dac_sclk  out  1  serial clock, idles low.
- dac_sync_n  out  1  frame select, active low, idles high.
- dac_sdo  out  1  serial data.
- dac_ldac_n  out  1  DAC load strobe, active low, idles high.
- frame_busy  out  1  high from LATCH through LDAC.
- frame_count  out  32  completed frames, wraps at 2^32.

Behaviour:
- Reset, asynchronous on a_resetn low (including mid-frame):
  - dac_sclk=0, dac_sync_n=1, dac_sdo=0, dac_ldac_n=1.
  - All tready=0, frame_busy=0, frame_count=0, FSM→IDLE.
  - An interrupted frame is abandoned; no LDAC is issued.
- FSM states: IDLE, LATCH, SHIFT, GAP, LDAC.
- IDLE → LATCH when all four tvalid=1 on the same cycle.
  - If any tvalid is low, stay in IDLE. No partial latching.
- LATCH, 1 cycle:
  - All four tready=1 in this cycle only; handshake completes on all channels simultaneously.
  - Register the four tdata values and convert each to a code.
  - Channel index ch←0.
  - tready is 0 in every other state, so further samples are not consumed until the frame ends (upstream holds).
- Conversion: v = $signed(tdata) >>> GAIN_SHIFT, then clamp to [-524288, +524287]. code = v[19:0].
- Channel word, 24 bits: {4'(ch+1), code[19:0]}, sent MSB first.
- SHIFT: dac_sync_n=0 for exactly 48*CLK_DIV cycles, i.e. 24 SCLK periods.
  - Each period = CLK_DIV cycles with SCLK low, then CLK_DIV cycles with SCLK high.
  - dac_sdo changes only on the first low cycle of each period and is stable across the rising edge.
  - After the last high half: SCLK→0, go to GAP.
- GAP: dac_sync_n=1, dac_sclk=0 for GAP_CYCLES cycles.
  - If ch<3: ch++, go to SHIFT.
  - Otherwise go to LDAC.
- LDAC: dac_ldac_n=0 for LDAC_CYCLES cycles, then frame_count++ and return to IDLE.
- Frame length: 1 + 4*(48*CLK_DIV + GAP_CYCLES) + LDAC_CYCLES cycles; 403 with defaults.
- Back-to-back frames: with tvalid held high, the next LATCH occurs the cycle after IDLE is entered (1 idle cycle between frames).
- frame_busy=1 in LATCH, SHIFT, GAP and LDAC.

Optional Feature:
- Macro: SPM_DAC_SATURATE_EN.
- Defined: clamp as described above.
- Undefined: no clamp; code = v[19:0] (two's-complement wrap). Saves comparators.

Test Plan:
- Defaults, all tvalid=1, tdata X=0x00010000, Y=0xFFFF0000, Z=0, U=0x00000100:
  - Frame of 403 cycles.
  - Words 0x100100, 0x2FFF00, 0x300000, 0x400001.
  - One LDAC low for 2 cycles; frame_count=1.
  - Check: tready pulses 1 cycle; SDO stable while SCLK high; 24 rising edges per sync_n low window.
- X=0x7FFFFFFF, Y=0x80000000:
  - With macro: codes 0x7FFFF and 0x80000.
  - Without macro: codes 0xFFFFF and 0x00000.
- S_AXIS3_tvalid=0 with the other three valid:
  - Stays IDLE, all tready=0, bus idle.
  - Raising tvalid starts LATCH on the next cycle.
- a_resetn pulsed low during channel-2 SHIFT:
  - Outputs immediately return to reset values; no LDAC; frame_count=0.
  - After release, a full frame completes normally.
- Continuous valid for 3 frames:
  - frame_count=3.
  - LATCH events spaced 404 cycles apart.
  - Each frame uses the sample present at its LATCH cycle.
- CLK_DIV=1, GAP_CYCLES=1, LDAC_CYCLES=1:
  - Frame length 1 + 4*49 + 1 = 198 cycles.
  - SCLK period 2 cycles.
